// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master command port among NUM_REQ
// requesters; latches the winning command and returns rdata plus a one-hot completion pulse.
//
// state | meaning
// IDLE  | no command in flight; arbitrate among raised req_transfer bits
// GRANT | latched command presented to the master until ready
// DONE  | one-cycle req_ready pulse to the granted requester

module axi_lite_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [NUM_REQ-1:0]          req_transfer,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           req_rdata,
  output logic                        transfer,
  output logic                        write,
  output logic [ADDR_W-1:0]           addr,
  output logic [DATA_W-1:0]           wdata,
  input  logic                        ready,
  input  logic [DATA_W-1:0]           rdata,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     rr_nxt;
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [IDW:0]       sum;
  logic [IDW-1:0]     cand;
  logic               win_write;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;
  logic [NUM_REQ-1:0] grant_onehot;

  // Search from rr_ptr upward, wrapping; the first raised request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) begin
        sum = sum - (IDW+1)'(NUM_REQ);
      end
      cand = sum[IDW-1:0];
      if (!win_found && req_transfer[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_write = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDW'(k)) begin
        win_write = req_write[k];
        win_addr  = req_addr[k*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    if (win_idx == IDW'(NUM_REQ-1)) begin
      rr_nxt = '0;
    end else begin
      rr_nxt = win_idx + IDW'(1);
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == IDW'(k)) begin
        grant_onehot[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = GRANT;
      GRANT:   if (ready)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // transfer/busy are flopped from the next state so every output comes from a register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rr_ptr    <= '0;
      grant_id  <= '0;
      write     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      transfer  <= 1'b0;
      busy      <= 1'b0;
      req_ready <= '0;
      req_rdata <= '0;
    end else begin
      transfer  <= (state_nxt == GRANT);
      busy      <= (state_nxt != IDLE);
      req_ready <= '0;
      if (state == IDLE && win_found) begin
        write    <= win_write;
        addr     <= win_addr;
        wdata    <= win_wdata;
        grant_id <= win_idx;
        rr_ptr   <= rr_nxt;
      end
      if (state == GRANT && ready) begin
        req_ready <= grant_onehot;
        if (!write) begin
          req_rdata <= rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Scoreboard bench for axi_lite_cmd_arbiter: directed requests push expected master
// commands and completions; independent monitors pop and compare.

module tb_axi_lite_cmd_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              ACLK;
  logic              ARESET;
  logic [NR-1:0]     req_transfer;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     req_rdata;
  logic              transfer;
  logic              write;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic              ready;
  logic [DW-1:0]     rdata;
  logic [1:0]        grant_id;
  logic              busy;

  typedef struct {
    int          id;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
  } txn_t;

  txn_t cmd_q[$];
  txn_t cpl_q[$];

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  logic [31:0] mem_rdata = 32'h1234_5678;

  axi_lite_cmd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_transfer(req_transfer), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_rdata(req_rdata),
    .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata),
    .grant_id(grant_id), .busy(busy)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic expect_txn(input int id, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] rd, input bit cpl);
    txn_t t;
    t.id = id; t.w = w; t.a = a; t.d = d; t.rd = rd;
    cmd_q.push_back(t);
    if (cpl) cpl_q.push_back(t);
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_write[i]           = w;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_transfer[i]        = 1'b1;
  endtask

  // Requesters drop req_transfer as soon as they see their req_ready.
  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (1) begin
      @(negedge ACLK);
      req_transfer = req_transfer & ~req_ready;
      if (req_transfer == '0 && busy == 1'b0) break;
      n++;
      if (n > budget) begin
        checks++;
        errors++;
        $display("FAIL run_timeout actual=%0d cycles required<=%0d", n, budget);
        req_transfer = '0;
        break;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_transfer"},  transfer,  0);
    chk({tag, "_write"},     write,     0);
    chk({tag, "_addr"},      addr,      0);
    chk({tag, "_wdata"},     wdata,     0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_req_rdata"}, req_rdata, 0);
    chk({tag, "_grant_id"},  grant_id,  0);
    chk({tag, "_busy"},      busy,      0);
  endtask

  // Master model: pulses ready after lat cycles of transfer.
  initial begin
    int cnt;
    cnt   = 0;
    ready = 1'b0;
    rdata = '0;
    forever begin
      @(negedge ACLK);
      if (ARESET || transfer !== 1'b1 || ready) begin
        ready = 1'b0;
        cnt   = 0;
      end else begin
        cnt++;
        if (cnt >= lat) begin
          ready = 1'b1;
          rdata = mem_rdata;
        end
      end
    end
  end

  // Command monitor: new grant on each transfer rise, held stable while transfer stays high.
  logic prev_transfer = 1'b0;
  txn_t cur_cmd;
  initial begin
    cur_cmd = '{id: 0, w: 1'b0, a: 32'h0, d: 32'h0, rd: 32'h0};
    forever begin
      @(negedge ACLK);
      if (transfer === 1'b1 && !prev_transfer) begin
        if (cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected actual grant_id=%0d addr=%h required none", grant_id, addr);
        end else begin
          cur_cmd = cmd_q.pop_front();
          chk("cmd_write",    write,    cur_cmd.w);
          chk("cmd_addr",     addr,     cur_cmd.a);
          chk("cmd_wdata",    wdata,    cur_cmd.d);
          chk("cmd_grant_id", grant_id, cur_cmd.id);
          chk("cmd_busy",     busy,     1);
        end
      end else if (transfer === 1'b1 && prev_transfer) begin
        chk("hold_write", write, cur_cmd.w);
        chk("hold_addr",  addr,  cur_cmd.a);
        chk("hold_wdata", wdata, cur_cmd.d);
        chk("hold_busy",  busy,  1);
      end
      prev_transfer = (transfer === 1'b1);
    end
  end

  // Completion monitor.
  initial begin
    txn_t t;
    logic [NR-1:0] oh;
    forever begin
      @(negedge ACLK);
      if (req_ready !== '0 && req_ready !== 'x) begin
        if (cpl_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpl_unexpected actual req_ready=%b required 0000", req_ready);
        end else begin
          t  = cpl_q.pop_front();
          oh = '0;
          oh[t.id] = 1'b1;
          chk("cpl_req_ready", req_ready, oh);
          chk("cpl_req_rdata", req_rdata, t.rd);
          chk("cpl_transfer",  transfer,  0);
          chk("cpl_busy",      busy,      1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESET       = 1'b1;
    req_transfer = '0;
    req_write    = '0;
    req_addr     = '0;
    req_wdata    = '0;
    repeat (2) @(negedge ACLK);
    chk_reset_outputs("rst0");
    ARESET = 1'b0;

    // Single write from requester 0.
    expect_txn(0, 1'b1, 32'h0, 32'hDEED_BEEF, 32'h0, 1'b1);
    set_req(0, 1'b1, 32'h0, 32'hDEED_BEEF);
    run_until_idle(50);

    ARESET = 1'b1;
    @(negedge ACLK);
    chk_reset_outputs("rst1");
    ARESET = 1'b0;

    // Contention from rr_ptr=0: order 0,1,2,3.
    for (int i = 0; i < NR; i++)
      expect_txn(i, 1'b1, 32'(i*4), 32'hDEED_BEE0 + 32'(i), 32'h0, 1'b1);
    for (int i = 0; i < NR; i++)
      set_req(i, 1'b1, 32'(i*4), 32'hDEED_BEE0 + 32'(i));
    run_until_idle(100);

    // Last grant 2, then req1 and req3 together: 3 wins first.
    expect_txn(2, 1'b1, 32'h28, 32'hAAAA_0002, 32'h0, 1'b1);
    set_req(2, 1'b1, 32'h28, 32'hAAAA_0002);
    run_until_idle(50);
    expect_txn(3, 1'b1, 32'h3C, 32'hBBBB_0003, 32'h0, 1'b1);
    expect_txn(1, 1'b1, 32'h14, 32'hBBBB_0001, 32'h0, 1'b1);
    set_req(1, 1'b1, 32'h14, 32'hBBBB_0001);
    set_req(3, 1'b1, 32'h3C, 32'hBBBB_0003);
    run_until_idle(100);

    // Read by req2, then a write that must leave req_rdata untouched.
    mem_rdata = 32'hDEED_BEE1;
    expect_txn(2, 1'b0, 32'h8, 32'h0, 32'hDEED_BEE1, 1'b1);
    set_req(2, 1'b0, 32'h8, 32'h0);
    run_until_idle(50);
    mem_rdata = 32'h1234_5678;
    expect_txn(0, 1'b1, 32'h40, 32'hCCCC_0000, 32'hDEED_BEE1, 1'b1);
    set_req(0, 1'b1, 32'h40, 32'hCCCC_0000);
    run_until_idle(50);

    // Stalled master: req3 held in GRANT for 20 cycles while req1 waits.
    lat = 20;
    expect_txn(3, 1'b1, 32'h30, 32'hA5A5_0003, 32'hDEED_BEE1, 1'b1);
    expect_txn(1, 1'b1, 32'h10, 32'h5A5A_0001, 32'hDEED_BEE1, 1'b1);
    set_req(3, 1'b1, 32'h30, 32'hA5A5_0003);
    repeat (3) @(negedge ACLK);
    set_req(1, 1'b1, 32'h10, 32'h5A5A_0001);
    run_until_idle(200);

    // Reset mid-GRANT: req2's transaction is dropped, then req0 before req1.
    expect_txn(2, 1'b1, 32'h20, 32'h2222_2222, 32'h0, 1'b0);
    set_req(2, 1'b1, 32'h20, 32'h2222_2222);
    repeat (4) @(negedge ACLK);
    chk("pre_rst_busy", busy, 1);
    ARESET          = 1'b1;
    req_transfer[2] = 1'b0;
    expect_txn(0, 1'b1, 32'h50, 32'hEEEE_0000, 32'h0, 1'b1);
    expect_txn(1, 1'b1, 32'h54, 32'hEEEE_0001, 32'h0, 1'b1);
    set_req(0, 1'b1, 32'h50, 32'hEEEE_0000);
    set_req(1, 1'b1, 32'h54, 32'hEEEE_0001);
    @(negedge ACLK);
    chk_reset_outputs("rst_mid");
    ARESET = 1'b0;
    lat    = 1;
    run_until_idle(100);
    repeat (3) @(negedge ACLK);

    chk("cmd_q_left", cmd_q.size(), 0);
    chk("cpl_q_left", cpl_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
